// File: rtl/clock_divider_multich_pkg.sv
// ============================================================================
// Module      : clock_divider_multich_pkg
// Description : Shared channel state encodings and divider constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_divider_multich_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_HIGH = 2'd1,
    CH_LOW  = 2'd2
  } ch_state_t;

  localparam int MIN_DIV = 2;

endpackage

`default_nettype wire

// File: rtl/clock_divider_multich_if.sv
// ============================================================================
// Module      : clock_divider_multich_if
// Description : Control and divided-clock bundle for the multichannel divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_divider_multich_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 16
);

  logic [NUM_CH-1:0]           en_i;
  logic [NUM_CH*DIV_WIDTH-1:0] div_i;
  logic                        sync_i;
  logic [NUM_CH-1:0]           clk_o;
  logic [NUM_CH-1:0]           rise_o;
  logic [NUM_CH-1:0]           fall_o;
  logic [NUM_CH-1:0]           busy_o;

  modport master (
    output en_i, div_i, sync_i,
    input  clk_o, rise_o, fall_o, busy_o
  );

  modport slave (
    input  en_i, div_i, sync_i,
    output clk_o, rise_o, fall_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/clock_divider_multich_channel.sv
// ============================================================================
// Module      : clock_divider_channel
// Description : One divider channel: IDLE/HIGH/LOW FSM, phase counter, divisor latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_channel
  import clock_divider_multich_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_n,
  input  wire logic                 en_i,
  input  wire logic [DIV_WIDTH-1:0] div_i,
  input  wire logic                 sync_i,
  output logic                      clk_o,
  output logic                      rise_o,
  output logic                      fall_o,
  output logic                      busy_o
);

  ch_state_t            r_state, w_state;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt;
  logic [DIV_WIDTH-1:0] r_div, w_div;
  logic                 w_rise, w_fall;
  logic [DIV_WIDTH-1:0] w_eff_div;
  logic [DIV_WIDTH-1:0] w_high_len;
  logic [DIV_WIDTH-1:0] w_low_len;

  // Divisors below the minimum collapse to the fastest legal rate.
  assign w_eff_div  = (div_i < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div_i;
  assign w_low_len  = r_div >> 1;
  assign w_high_len = r_div - w_low_len;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state <= CH_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      clk_o   <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_div   <= w_div;
      clk_o   <= (w_state == CH_HIGH);
      rise_o  <= w_rise;
      fall_o  <= w_fall;
      busy_o  <= (w_state != CH_IDLE);
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + DIV_WIDTH'(1);
    w_div   = r_div;
    w_rise  = 1'b0;
    w_fall  = 1'b0;

    // Sync restarts an enabled channel at the top of a fresh period.
    if (sync_i && en_i) begin
      w_state = CH_HIGH;
      w_cnt   = '0;
      w_div   = w_eff_div;
      w_rise  = 1'b1;
    end else begin
      case (r_state)
        CH_IDLE: begin
          w_cnt = '0;
          if (en_i) begin
            w_state = CH_HIGH;
            w_div   = w_eff_div;
            w_rise  = 1'b1;
          end
        end
        CH_HIGH: begin
          if (r_cnt == w_high_len - DIV_WIDTH'(1)) begin
            w_state = CH_LOW;
            w_cnt   = '0;
            w_fall  = 1'b1;
          end
        end
        CH_LOW: begin
          if (r_cnt == w_low_len - DIV_WIDTH'(1)) begin
            w_cnt = '0;
            if (en_i) begin
              w_state = CH_HIGH;
              w_div   = w_eff_div;
              w_rise  = 1'b1;
            end else begin
              w_state = CH_IDLE;
            end
          end
        end
        default: begin
          w_state = CH_IDLE;
          w_cnt   = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_divider_multich.sv
// ============================================================================
// Module      : clock_divider_multich
// Description : NUM_CH independent runtime-programmable clock dividers with shared sync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_multich
  import clock_divider_multich_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 16
) (
  input  wire logic               clk_i,
  input  wire logic               rst_n,
  clock_divider_multich_if.slave  bus
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clock_divider_channel #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_channel (
      .clk_i  (clk_i),
      .rst_n  (rst_n),
      .en_i   (bus.en_i[k]),
      .div_i  (bus.div_i[k*DIV_WIDTH +: DIV_WIDTH]),
      .sync_i (bus.sync_i),
      .clk_o  (bus.clk_o[k]),
      .rise_o (bus.rise_o[k]),
      .fall_o (bus.fall_o[k]),
      .busy_o (bus.busy_o[k])
    );
  end

endmodule

`default_nettype wire
